// File: rtl/switch_bank.sv
// Multi-channel switch front end: a 2-FF synchroniser per pin, then a per-channel
// debounce counter advanced on i_sample strobes, with registered rise/fall pulses.
module switch_bank #(
  parameter int                WIDTH        = 8,
  parameter int                STABLE_COUNT = 4,
  parameter int                ACTIVE_LOW   = 0,
  parameter logic [WIDTH-1:0]  INIT         = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_switch,
  input  logic             i_sample,
  output logic [WIDTH-1:0] o_switch,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall,
  output logic             o_changed
);

  localparam int               CW        = ($clog2(STABLE_COUNT + 1) > 1) ? $clog2(STABLE_COUNT + 1) : 1;
  localparam logic [CW-1:0]    CNT_LAST  = CW'(STABLE_COUNT - 1);
  localparam logic [WIDTH-1:0] INV       = {WIDTH{ACTIVE_LOW != 0}};
  // Sync stages start at the raw level matching INIT so release never produces an edge.
  localparam logic [WIDTH-1:0] SYNC_INIT = INIT ^ INV;

  if (WIDTH < 1 || STABLE_COUNT < 1) begin : g_bad_param
    $error("switch_bank: WIDTH and STABLE_COUNT must both be >= 1");
  end

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] lvl;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_nxt  [WIDTH];
  logic [WIDTH-1:0] sw_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;

  assign lvl = sync2 ^ INV;

  always_comb begin
    sw_nxt   = o_switch;
    rise_nxt = '0;
    fall_nxt = '0;
    cnt_nxt  = cnt;
    if (i_sample) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (lvl[i] == o_switch[i]) begin
          // A bounce back to the accepted level cancels any pending change.
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_nxt[i]   = lvl[i];
          cnt_nxt[i]  = '0;
          rise_nxt[i] = lvl[i];
          fall_nxt[i] = ~lvl[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1     <= SYNC_INIT;
      sync2     <= SYNC_INIT;
      o_switch  <= INIT;
      o_rise    <= '0;
      o_fall    <= '0;
      o_changed <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1     <= i_switch;
      sync2     <= sync1;
      o_switch  <= sw_nxt;
      o_rise    <= rise_nxt;
      o_fall    <= fall_nxt;
      o_changed <= |(rise_nxt | fall_nxt);
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

endmodule

// File: tb/tb_switch_bank.sv
// Bench for switch_bank: three instances (active-high, active-low, single-sample
// with non-zero INIT) against a streak-counting reference model plus directed checks.
module tb_switch_bank;
  localparam int NI = 3;

  logic       i_clk    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       i_sample = 1'b0;
  logic [3:0] sw   [NI];
  logic [3:0] o_sw [NI];
  logic [3:0] o_ri [NI];
  logic [3:0] o_fa [NI];
  logic       o_ch [NI];

  int total = 0;
  int bad   = 0;
  int smp_mode = 0;
  int cyc = 0;
  bit chk_en = 0;
  int chg_cnt [NI];
  int ri_cnt  [4];
  logic [3:0] last_ri [NI];
  logic [3:0] last_fa [NI];
  int n_acc;
  int rk, rc;

  always #5 i_clk = ~i_clk;

  switch_bank #(.WIDTH(4), .STABLE_COUNT(3), .ACTIVE_LOW(0), .INIT(4'b0000)) dut_a (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_switch(sw[0]), .i_sample(i_sample),
    .o_switch(o_sw[0]), .o_rise(o_ri[0]), .o_fall(o_fa[0]), .o_changed(o_ch[0]));
  switch_bank #(.WIDTH(4), .STABLE_COUNT(3), .ACTIVE_LOW(1), .INIT(4'b0000)) dut_b (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_switch(sw[1]), .i_sample(i_sample),
    .o_switch(o_sw[1]), .o_rise(o_ri[1]), .o_fall(o_fa[1]), .o_changed(o_ch[1]));
  switch_bank #(.WIDTH(4), .STABLE_COUNT(1), .ACTIVE_LOW(0), .INIT(4'b1010)) dut_c (
    .i_clk(i_clk), .i_rst_n(rst_n), .i_switch(sw[2]), .i_sample(i_sample),
    .o_switch(o_sw[2]), .o_rise(o_ri[2]), .o_fall(o_fa[2]), .o_changed(o_ch[2]));

  function automatic logic [3:0] mask_of(input int k);
    return (k == 1) ? 4'hF : 4'h0;
  endfunction
  function automatic logic [3:0] init_of(input int k);
    return (k == 2) ? 4'b1010 : 4'b0000;
  endfunction
  function automatic int sc_of(input int k);
    return (k == 2) ? 1 : 3;
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Reference model: pins reach the debouncer two edges late; a channel flips once
  // STABLE_COUNT consecutive strobes have seen a level different from the accepted one.
  logic [3:0] m_h1 [NI], m_h2 [NI], m_sw [NI], m_ri [NI], m_fa [NI], m_lvl [NI];
  logic       m_ch [NI];
  int         m_run [NI][4];

  initial forever begin
    @(posedge i_clk or negedge rst_n);
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        m_sw[k] = init_of(k);
        m_ri[k] = '0;
        m_fa[k] = '0;
        m_ch[k] = 1'b0;
        m_h1[k] = init_of(k) ^ mask_of(k);
        m_h2[k] = m_h1[k];
        for (int c = 0; c < 4; c++) m_run[k][c] = 0;
      end else begin
        m_lvl[k] = m_h2[k] ^ mask_of(k);
        m_ri[k] = '0;
        m_fa[k] = '0;
        if (i_sample) begin
          for (int c = 0; c < 4; c++) begin
            if (m_lvl[k][c] == m_sw[k][c]) m_run[k][c] = 0;
            else begin
              m_run[k][c] = m_run[k][c] + 1;
              if (m_run[k][c] >= sc_of(k)) begin
                m_sw[k][c] = m_lvl[k][c];
                if (m_lvl[k][c]) m_ri[k][c] = 1'b1;
                else             m_fa[k][c] = 1'b1;
                m_run[k][c] = 0;
              end
            end
          end
        end
        m_ch[k] = (m_ri[k] | m_fa[k]) != 4'b0;
        m_h2[k] = m_h1[k];
        m_h1[k] = sw[k];
      end
    end
  end

  initial forever begin
    @(negedge i_clk);
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        check($sformatf("sw%0d", k),   o_sw[k], m_sw[k]);
        check($sformatf("rise%0d", k), o_ri[k], m_ri[k]);
        check($sformatf("fall%0d", k), o_fa[k], m_fa[k]);
        check($sformatf("chg%0d", k),  {3'b0, o_ch[k]}, {3'b0, m_ch[k]});
      end
    end
    for (int k = 0; k < NI; k++) begin
      if (o_ch[k] === 1'b1) begin
        chg_cnt[k]++;
        last_ri[k] = o_ri[k];
        last_fa[k] = o_fa[k];
      end
    end
    for (int c = 0; c < 4; c++) if (o_ri[0][c] === 1'b1) ri_cnt[c]++;
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    cyc++;
    case (smp_mode)
      0:       i_sample = (cyc % 4 == 0);
      1:       i_sample = 1'b1;
      default: i_sample = ($urandom_range(0, 2) == 0);
    endcase
  end

  // Counts strobes that see the new level (third edge after the change onward)
  // until the channel flips; -1 if it never does.
  task automatic count_accept(input int k, input int ch, output int n);
    logic start;
    bit   done;
    start = o_sw[k][ch];
    n = 0;
    done = 0;
    for (int e = 1; e <= 200 && !done; e++) begin
      @(posedge i_clk);
      if (e >= 3 && i_sample) n++;
      #2;
      if (o_sw[k][ch] !== start) done = 1;
    end
    if (!done) n = -1;
  endtask

  task automatic hold_samples(input int k, input int ch, input logic v, input int n);
    int seen;
    seen = 0;
    sw[k][ch] = v;
    for (int e = 0; e < 400 && seen < n; e++) begin
      @(posedge i_clk);
      if (i_sample) seen++;
    end
    #1;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NI; k++) begin
      chg_cnt[k] = 0;
      last_ri[k] = '0;
      last_fa[k] = '0;
    end
    for (int c = 0; c < 4; c++) ri_cnt[c] = 0;
  endtask

  initial begin
    sw[0] = 4'b0000;
    sw[1] = 4'hF;
    sw[2] = 4'b1010;
    clear_counts();
    repeat (3) step();
    chk_en = 1;
    rst_n = 1'b1;

    repeat (100) step();
    check("idle_chg_a", 4'(chg_cnt[0]), 4'd0);
    check("idle_chg_b", 4'(chg_cnt[1]), 4'd0);
    check("idle_chg_c", 4'(chg_cnt[2]), 4'd0);
    check("idle_sw_b",  o_sw[1], 4'b0000);

    sw[0][0] = 1'b1;
    count_accept(0, 0, n_acc);
    check("accept_n_a0", 4'(n_acc), 4'd3);
    check("accept_rise", o_ri[0], 4'b0001);
    check("accept_fall", o_fa[0], 4'b0000);
    check("accept_chg",  {3'b0, o_ch[0]}, 4'b0001);
    step();
    check("rise_one_cyc", o_ri[0], 4'b0000);

    while (!i_sample) step();
    step();
    clear_counts();
    hold_samples(0, 1, 1'b1, 2);
    hold_samples(0, 1, 1'b0, 1);
    check("bounce_no_early", {3'b0, o_sw[0][1]}, 4'b0000);
    hold_samples(0, 1, 1'b1, 3);
    check("bounce_accept", {3'b0, o_sw[0][1]}, 4'b0001);
    repeat (20) step();
    check("bounce_one_rise", 4'(ri_cnt[1]), 4'd1);

    sw[0][2] = 1'b1;
    repeat (30) step();
    clear_counts();
    sw[0][2] = 1'b0;
    sw[0][3] = 1'b1;
    repeat (30) step();
    check("simul_chg_cnt", 4'(chg_cnt[0]), 4'd1);
    check("simul_fall",    last_fa[0], 4'b0100);
    check("simul_rise",    last_ri[0], 4'b1000);

    sw[1][0] = 1'b0;
    count_accept(1, 0, n_acc);
    check("al_accept_n", 4'(n_acc), 4'd3);
    check("al_sw",       o_sw[1], 4'b0001);
    check("al_rise",     o_ri[1], 4'b0001);

    sw[0][0] = 1'b0;
    repeat (30) step();
    check("pre_rst_sw0", {3'b0, o_sw[0][0]}, 4'b0000);
    sw[0][0] = 1'b1;
    for (int e = 0; e < 100 && m_run[0][0] != 2; e++) step();
    check("pre_rst_run", 4'(m_run[0][0]), 4'd2);
    rst_n = 1'b0;
    #1;
    check("rst_imm_sw",  o_sw[0], 4'b0000);
    check("rst_imm_sw_c", o_sw[2], 4'b1010);
    check("rst_imm_rise", o_ri[0], 4'b0000);
    repeat (3) step();
    rst_n = 1'b1;
    count_accept(0, 0, n_acc);
    check("rst_fresh_n", 4'(n_acc), 4'd3);

    for (int r = 0; r < 3000; r++) begin
      step();
      if (r % 200 == 0) smp_mode = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) begin
        rk = $urandom_range(0, NI - 1);
        rc = $urandom_range(0, 3);
        sw[rk][rc] = ~sw[rk][rc];
      end
      if (r % 1000 == 777) begin
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
